// File: rtl/data_mem_arbiter.sv
// Two-port req/gnt arbiter and sequencer in front of the single-ported data_memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build uses fixed priority (port 0 wins).
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              mem_read_flag,
  output logic              mem_write_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_val,
  input  logic [DATA_W-1:0] mem_read_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_d;
  logic              sel, sel_d;
  logic              gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
  logic              rflag_d, wflag_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] val_d, rdata0_d, rdata1_d;
  logic              pick1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last, last_d;
  // Port 1 wins when port 0 is not requesting, or on a tie when port 0 was granted last
  assign pick1 = req1 & (~req0 | ~last);
`else
  assign pick1 = req1 & ~req0;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state;
    sel_d     = sel;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rflag_d   = 1'b0;
    wflag_d   = 1'b0;
    addr_d    = mem_addr;
    val_d     = mem_val;
    rdata0_d  = rdata0;
    rdata1_d  = rdata1;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last;
`endif
    case (state)
      IDLE, RESP: begin
        if (req0 | req1) begin
          state_d = ACCESS;
          sel_d   = pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          wflag_d = pick1 ? we1 : we0;
          rflag_d = pick1 ? ~we1 : ~we0;
          addr_d  = pick1 ? addr1 : addr0;
          val_d   = pick1 ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Read data is sampled from the asynchronous memory output at the edge ending ACCESS
        if (mem_read_flag) begin
          if (sel) begin
            rdata1_d  = mem_read_out;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_read_out;
            rvalid0_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sel            <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      mem_read_flag  <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_addr       <= '0;
      mem_val        <= '0;
      rdata0         <= '0;
      rdata1         <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last           <= 1'b1;
`endif
    end else begin
      state          <= state_d;
      sel            <= sel_d;
      gnt0           <= gnt0_d;
      gnt1           <= gnt1_d;
      rvalid0        <= rvalid0_d;
      rvalid1        <= rvalid1_d;
      mem_read_flag  <= rflag_d;
      mem_write_flag <= wflag_d;
      mem_addr       <= addr_d;
      mem_val        <= val_d;
      rdata0         <= rdata0_d;
      rdata1         <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last           <= last_d;
`endif
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported `data_memory` block. It lets the core load/store stage (port 0) and a secondary requester such as a debug or DMA engine (port 1) share the memory. Each port uses a req/gnt handshake. The arbiter drives the memory's read/write flags, address and write data from registers, and returns read data per port with a one-cycle valid pulse.

## Interface
- `ADDR_W`, default 32: address width of both ports and of the memory address.
- `DATA_W`, default 32: data width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req0` in 1: port 0 request.
- `we0` in 1: port 0 write enable (1 = write, 0 = read).
- `addr0` in ADDR_W: port 0 byte address.
- `wdata0` in DATA_W: port 0 write data.
- `gnt0` out 1: port 0 grant (acceptance pulse).
- `rdata0` out DATA_W: port 0 read data.
- `rvalid0` out 1: port 0 read data valid.
- `req1`, `we1`, `addr1`, `wdata1`, `gnt1`, `rdata1`, `rvalid1`: same as the port 0 signals, for port 1.
- `mem_read_flag` out 1: drives the memory's read flag.
- `mem_write_flag` out 1: drives the memory's write flag.
- `mem_addr` out ADDR_W: drives the memory address.
- `mem_val` out DATA_W: drives the memory write data.
- `mem_read_out` in DATA_W: asynchronous read data from the memory.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: memory flags asserted for exactly this cycle.
  - RESP: read data returned.
- Arbitration is evaluated in IDLE and RESP on the current `req0`/`req1`.
  - If any request is present, the winner's `we`, `addr` and `wdata` are registered into `mem_write_flag`/`mem_read_flag`, `mem_addr` and `mem_val`, and the FSM moves to ACCESS.
  - With no request, IDLE stays in IDLE and RESP goes to IDLE.
- ACCESS:
  - The granted port's `gnt` is high for this one cycle.
  - A write commits to memory at the rising edge ending ACCESS.
  - A read captures `mem_read_out` at that edge into the port's `rdata`.
  - ACCESS always goes to RESP.
- RESP:
  - `mem_read_flag` and `mem_write_flag` are 0.
  - `rvalid` of the granted port is 1 for this cycle if the access was a read; writes produce no `rvalid`.
- Handshake rules:
  - A requester holds `req`/`we`/`addr`/`wdata` stable until it samples `gnt` high.
  - In the following cycle it lowers `req` or presents a new request.
  - Dropping `req` before `gnt` withdraws the request; this is legal only in cycles where that port is not being registered.
- `rdataN` holds its last read value until the next read for that port. The other port's `rdata` is unaffected.
- Outside ACCESS, `mem_addr`/`mem_val` hold their last values.
- Addresses pass through unmodified; the memory word-indexes `addr[6:2]`. Misaligned or out-of-range addresses alias and are not flagged.
- At most one grant is outstanding at any time. `gnt0` and `gnt1` are never high together.

## Timing
- Request present at edge N (state IDLE): ACCESS in cycle N+1 with `gnt` high; RESP in cycle N+2 with `rvalid`/`rdata` for a read.
- Back-to-back: a request present during RESP goes directly to ACCESS, so sustained throughput is one access per 2 cycles.
- Simultaneous requests: resolved by the arbitration policy (see Configuration). The loser keeps `req` high and is considered again at the next RESP.
- Reset values (state IDLE, all outputs zero):
  - `gnt0`, `gnt1`, `rvalid0`, `rvalid1` = 0.
  - `rdata0`, `rdata1` = 0.
  - `mem_read_flag`, `mem_write_flag` = 0.
  - `mem_addr`, `mem_val` = 0.
  - Round-robin pointer = port 1, so port 0 wins the first tie.
- `rst` takes priority in every state. If asserted during ACCESS or RESP:
  - the in-flight response is dropped and no `rvalid` follows;
  - all outputs are at reset values in the cycle after the reset edge.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - The last-granted pointer updates on every grant.
  - On a tie the port not granted last wins.
  - A port with `req` held continuously is served within 2 accesses.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; port 0 always wins a tie.
  - Port 1 is served only when `req0` is low at an arbitration point.
  - No pointer register.

## Test plan
- Reset, then port 0 read of addr 0x0 (`req0`=1 at edge N) -> `gnt0`=1 in N+1; `rvalid0`=1 and `rdata0`=0x0000000F in N+2; `mem_read_flag` high only in N+1.
- Port 1 write of 0xDEADBEEF to 0x8, then port 0 read of 0x8 -> `gnt1` pulse with no `rvalid1`; `rdata0`=0xDEADBEEF; `rdata1` unchanged.
- Both ports request continuously with reads to 0x4/0xC:
  - with `ARB_ROUND_ROBIN_EN`: grant order 0,1,0,1;
  - without it: four consecutive `gnt0` and `gnt1` stays 0.
- Port 0 issues 3 reads back-to-back to 0x0, 0x4 and 0x8, presenting a new address after each grant -> `gnt0` pulses every 2 cycles; `rvalid0` pulses 1 cycle after each `gnt0`.
- `rst` asserted during ACCESS of a port 0 read -> no `rvalid0`; all outputs 0 in the next cycle; a request issued after reset deasserts completes with normal latency.
- Port 1 read of addr 0x84 after writing 0x12345678 to 0x4 -> `rdata1`=0x12345678 (alias to word 1); no error indication.
